// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and requester ids for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_id_e;
endpackage

// File: rtl/mem_arb_wait_timer.sv
// mem_arb_wait_timer: counts WAIT cycles; expired flags the TIMEOUT-th one.
module mem_arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = en && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory between fetch and data ports,
// with anti-starvation for fetch and a sticky protocol/timeout error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  state_e            state_q, state_d;
  req_id_e           win_q, win_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              wr_q, wr_d, err_q, err_d, if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              busy, owner_req, expired;
  assign busy      = state_q == ISSUE || state_q == WAIT;
  assign owner_req = win_q == REQ_D ? d_req : if_req;
  assign pick      = (d_req && !(if_req && starve_q == SW'(MAX_WAIT))) ? REQ_D : REQ_IF;
  mem_arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != WAIT),
    .en      (state_q == WAIT),
    .expired (expired)
  );
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q | (busy && !owner_req);
    case (state_q)
      IDLE: if (if_req || d_req) begin
        state_d  = ISSUE;
        win_d    = pick;
        addr_d   = pick == REQ_D ? d_addr : if_addr;
        wdata_d  = pick == REQ_D ? d_wdata : '0;
        wr_d     = pick == REQ_D && d_wr;
        starve_d = pick == REQ_IF ? '0 :
                   (if_req && starve_q != SW'(MAX_WAIT)) ? starve_q + 1'b1 : starve_q;
      end
      ISSUE: state_d = WAIT;
      // m_ready beats the timeout when both land on the same cycle
      WAIT: if (m_ready || expired) begin
        state_d = DONE;
        err_d   = err_d | !m_ready;
        if (win_q == REQ_D) d_rdata_d = (m_ready && !wr_q) ? m_rdata : '0;
        else if_rdata_d = m_ready ? m_rdata : '0;
      end
      default: state_d = IDLE;
    endcase
    if_gnt_d = state_d != IDLE && win_d == REQ_IF;
    d_gnt_d  = state_d != IDLE && win_d == REQ_D;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= REQ_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
    end
  assign if_gnt   = if_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_done  = state_q == DONE && win_q == REQ_IF;
  assign d_done   = state_q == DONE && win_q == REQ_D;
  assign m_en     = state_q == ISSUE;
  assign m_wr     = busy && wr_q;
  assign m_addr   = busy ? addr_q : '0;
  assign m_wdata  = busy ? wdata_q : '0;
  assign err      = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single accesses plus hand sequences for
// arbitration, timeout, protocol error and async reset; scoreboard on done.
module tb_mem_arbiter;
  localparam int TIMEOUT = 16;
  localparam int MAX_WAIT = 4;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_req = 0, d_wr = 0, m_ready = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic if_gnt, if_done, d_gnt, d_done, m_en, m_wr, err;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rdata(if_rdata), .if_done(if_done), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done), .m_en(m_en),
    .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .err(err));

  always #5 clk = ~clk;

  typedef struct {logic is_d; logic wr; logic [15:0] addr; logic [15:0] wdata;
                  int lat; logic [15:0] mdata; logic [15:0] exp_rd;} vec_t;
  typedef struct packed {logic port; logic [15:0] rd;} exp_t;
  exp_t sb[$];
  logic gnt_log[$];
  int checks = 0, failures = 0;
  logic resp_on = 1, pending = 0, prev_m_en = 0;
  int resp_lat = 0, cnt = 0;
  logic [15:0] resp_data = 0, last_addr = 0, last_wdata = 0;
  logic last_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: answers resp_lat cycles after the first WAIT cycle
  initial forever begin
    @(negedge clk);
    m_ready = 0;
    if (!rst_n) pending = 0;
    else if (pending) begin
      if (cnt == 0) begin
        m_ready = 1;
        m_rdata = resp_data;
        pending = 0;
      end else cnt--;
    end
    if (m_en) begin
      last_addr = m_addr;
      last_wr = m_wr;
      last_wdata = m_wdata;
      gnt_log.push_back(d_gnt);
      chk("one_gnt", {31'd0, if_gnt ^ d_gnt}, 1);
      if (resp_on) begin
        pending = 1;
        cnt = resp_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en && prev_m_en) chk("m_en_single_cycle", 1, 0);
    prev_m_en = m_en;
    if (if_done || d_done) begin
      if (if_done && d_done) chk("both_done", 1, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got if_done=%b d_done=%b expected none", if_done, d_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", {31'd0, d_done}, {31'd0, e.port});
        chk("done_rdata", {16'd0, d_done ? d_rdata : if_rdata}, {16'd0, e.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic want_d, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(want_d ? d_done : if_done) && cyc < 80);
    if (!(want_d ? d_done : if_done)) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic run_single(input vec_t v);
    int cyc;
    sb.push_back({v.is_d, v.exp_rd});
    resp_on = 1;
    resp_lat = v.lat;
    resp_data = v.mdata;
    d_wr = v.wr;
    d_wdata = v.wdata;
    if (v.is_d) begin d_addr = v.addr; d_req = 1; end
    else begin if_addr = v.addr; if_req = 1; end
    tick();
    chk("m_en_cycle1", {31'd0, m_en}, 1);
    chk("gnt_owner", {30'd0, d_gnt, if_gnt}, v.is_d ? 2 : 1);
    chk("m_addr", {16'd0, m_addr}, {16'd0, v.addr});
    chk("m_wr", {31'd0, m_wr}, {31'd0, v.wr});
    if (v.wr) chk("m_wdata", {16'd0, m_wdata}, {16'd0, v.wdata});
    tick();
    chk("m_en_cycle2", {31'd0, m_en}, 0);
    wait_done(v.is_d, cyc);
    chk("done_latency", cyc + 2, 3 + v.lat);
    if_req = 0;
    d_req = 0;
    d_wr = 0;
    tick();
    chk("idle_outputs", {28'd0, m_en, if_gnt, d_gnt, m_addr != 0}, 0);
  endtask

  vec_t vecs[6];
  initial begin
    int cyc, n;
    logic [9:0] exp_order;
    vecs[0] = '{0, 0, 16'h0040, 16'h0000, 0, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1, 0, 16'h0200, 16'h0000, 1, 16'h5A5A, 16'h5A5A};
    vecs[2] = '{1, 1, 16'h0300, 16'hCAFE, 0, 16'h7777, 16'h0000};
    vecs[3] = '{0, 0, 16'hFFFF, 16'h0000, 2, 16'h0001, 16'h0001};
    vecs[4] = '{1, 0, 16'h0000, 16'h0000, 5, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1, 1, 16'h1234, 16'h8001, 3, 16'h1111, 16'h0000};
    #2;
    chk("reset_outputs", {if_rdata, 9'd0, m_en, m_wr, if_gnt, d_gnt, if_done, d_done, err}, 0);
    chk("reset_outputs2", {d_rdata, m_addr}, 0);
    tick();
    rst_n = 1;
    tick();
    chk("post_reset_idle", {28'd0, m_en, if_gnt, d_gnt, err}, 0);
    foreach (vecs[i]) run_single(vecs[i]);
    chk("no_err_after_table", {31'd0, err}, 0);

    // simultaneous store and fetch: data wins, then fetch
    gnt_log.delete();
    sb.push_back({1'b1, 16'h0000});
    sb.push_back({1'b0, 16'h2222});
    resp_lat = 0;
    resp_data = 16'h2222;
    d_addr = 16'h0100; d_wdata = 16'h1234; d_wr = 1; d_req = 1;
    if_addr = 16'h0040; if_req = 1;
    tick();
    chk("tie_d_gnt", {30'd0, d_gnt, if_gnt}, 2);
    chk("tie_m_wr", {31'd0, m_wr}, 1);
    chk("tie_m_wdata", {16'd0, m_wdata}, 32'h1234);
    chk("tie_m_addr", {16'd0, m_addr}, 32'h0100);
    wait_done(1, cyc);
    d_req = 0; d_wr = 0;
    wait_done(0, cyc);
    if_req = 0;
    chk("tie_fetch_addr", {16'd0, last_addr}, 32'h0040);
    chk("tie_order", {30'd0, gnt_log[0], gnt_log[1]}, 2);
    tick();

    // both held: fetch forced after MAX_WAIT data grants
    gnt_log.delete();
    exp_order = 10'b1111011110;
    resp_data = 16'h3333;
    resp_lat = 1;
    for (int i = 0; i < 10; i++) sb.push_back({exp_order[9-i], 16'h3333});
    d_addr = 16'h0700; d_req = 1; if_addr = 16'h0080; if_req = 1;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (if_done || d_done) n++;
    end
    if_req = 0; d_req = 0;
    chk("starve_done_count", n, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_order_%0d", i), {31'd0, gnt_log[i]}, {31'd0, exp_order[9-i]});
    chk("starve_no_err", {31'd0, err}, 0);
    tick();

    // memory never answers: timeout after TIMEOUT WAIT cycles
    resp_on = 0;
    sb.push_back({1'b0, 16'h0000});
    if_addr = 16'h0050; if_req = 1;
    for (int c = 1; c <= TIMEOUT + 1; c++) tick();
    chk("timeout_err_early", {30'd0, err, if_done}, 0);
    tick();
    chk("timeout_err_done", {30'd0, err, if_done}, 3);
    if_req = 0;
    tick();
    run_single(vecs[1]);
    chk("err_sticky", {31'd0, err}, 1);

    // winner drops req during WAIT
    do_reset();
    chk("err_cleared", {31'd0, err}, 0);
    resp_on = 1; resp_lat = 3; resp_data = 16'h4444;
    sb.push_back({1'b1, 16'h4444});
    d_addr = 16'h0600; d_wr = 0; d_req = 1;
    tick();
    tick();
    chk("drop_err_before", {31'd0, err}, 0);
    d_req = 0;
    tick();
    chk("drop_err_after", {31'd0, err}, 1);
    wait_done(1, cyc);
    chk("drop_done_latency", cyc + 3, 6);
    tick();

    // async reset mid-WAIT
    do_reset();
    resp_on = 0;
    if_addr = 16'h0090; if_req = 1;
    tick(); tick(); tick();
    chk("pre_reset_gnt", {31'd0, if_gnt}, 1);
    rst_n = 0;
    #1;
    chk("async_reset_outs", {if_rdata, 9'd0, m_en, m_wr, if_gnt, d_gnt, if_done, d_done, err}, 0);
    chk("async_reset_outs2", {d_rdata, m_addr}, 0);
    if_req = 0;
    tick(); tick();
    rst_n = 1;
    for (int c = 0; c < 12; c++) tick();
    chk("post_abort_err", {31'd0, err}, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
